csr_encoder: RTL

//  Dense-to-CSR writer: accepts a row-major dense matrix stream and writes value,

---
 rtl/csr_encoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/csr_encoder.sv
// csr_encoder: turns a row-major dense element stream into CSR value, column and row-pointer RAM writes.
// Optional feature: define CSR_MAXROW_EN to add the max_row_nnz output and its per-row counter.
module csr_encoder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int NROWS  = 1120,
    parameter int NCOLS  = 1120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              val_we,
    output logic [ADDR_W-1:0] val_addr,
    output logic [DATA_W-1:0] val_din,
    output logic              col_we,
    output logic [ADDR_W-1:0] col_addr,
    output logic [DATA_W-1:0] col_din,
    output logic              row_we,
    output logic [ADDR_W-1:0] row_addr,
    output logic [DATA_W-1:0] row_din,
    output logic [ADDR_W:0]   nnz,
    output logic              done,
    output logic              overflow
`ifdef CSR_MAXROW_EN
    ,
    output logic [ADDR_W:0]   max_row_nnz
`endif
);

    localparam int ROW_W = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int COL_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ROW_W-1:0]   row_cnt;
    logic [COL_W-1:0]   col_cnt;
    logic               accept;
    logic               start_run;
    logic               last_col;
    logic               last_row;
    logic               is_nz;
    logic               store;

    assign in_ready  = (state == S_RUN);
    assign accept    = in_valid & in_ready;
    assign start_run = start & ((state == S_IDLE) | (state == S_DONE));
    assign last_col  = (col_cnt == COL_W'(NCOLS - 1));
    assign last_row  = (row_cnt == ROW_W'(NROWS - 1));
    assign is_nz     = (in_data != '0);
    // nnz[ADDR_W] set means nnz == 2**ADDR_W: the value RAM is full.
    assign store     = accept & is_nz & ~nnz[ADDR_W];

    // NOTE: reset here is synchronous, so it is only tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (accept && last_row && last_col) state_next = S_FLUSH;
            S_FLUSH: state_next = S_DONE;
            S_DONE:  if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt  <= '0;
            col_cnt  <= '0;
            nnz      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            val_we   <= 1'b0;
            val_addr <= '0;
            val_din  <= '0;
            col_we   <= 1'b0;
            col_addr <= '0;
            col_din  <= '0;
            row_we   <= 1'b0;
            row_addr <= '0;
            row_din  <= '0;
        end else begin
            val_we <= 1'b0;
            col_we <= 1'b0;
            row_we <= 1'b0;

            if (start_run) begin
                row_cnt  <= '0;
                col_cnt  <= '0;
                nnz      <= '0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end

            if (accept) begin
                if (col_cnt == '0) begin
                    row_we   <= 1'b1;
                    row_addr <= ADDR_W'(row_cnt);
                    row_din  <= DATA_W'(nnz);
                end
                if (store) begin
                    val_we   <= 1'b1;
                    val_addr <= nnz[ADDR_W-1:0];
                    val_din  <= in_data;
                    col_we   <= 1'b1;
                    col_addr <= nnz[ADDR_W-1:0];
                    col_din  <= DATA_W'(col_cnt);
                    nnz      <= nnz + (ADDR_W + 1)'(1);
                end else if (is_nz) begin
                    overflow <= 1'b1;
                end
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end

            // Terminating pointer: nnz already includes the final element here.
            if (state == S_FLUSH) begin
                row_we   <= 1'b1;
                row_addr <= ADDR_W'(NROWS);
                row_din  <= DATA_W'(nnz);
                done     <= 1'b1;
            end
        end
    end

`ifdef CSR_MAXROW_EN
    logic [ADDR_W:0] row_nnz;
    logic [ADDR_W:0] row_total;

    assign row_total = row_nnz + (ADDR_W + 1)'(store);

    always_ff @(posedge clk) begin
        if (reset || start_run) begin
            row_nnz     <= '0;
            max_row_nnz <= '0;
        end else if (accept) begin
            if (last_col) begin
                row_nnz <= '0;
                if (row_total > max_row_nnz) max_row_nnz <= row_total;
            end else begin
                row_nnz <= row_total;
            end
        end
    end
`endif

endmodule
